subtractor_pipe: RTL and testbench

Parametrised, pipelined A−B subtractor and magnitude comparator; successor to the fixed 8-bit borrow-only subtractor. Operands are split into STAGE_W-bit slices, and one slice is resolved per pipeline stage, with the borrow registered between stages. Returns full difference, borrow, and LT/EQ/GT flags in unsigned or signed mode. Valid/ready handshake on both sides; sits between operand-issue logic and compare/branch consumers.

---
 rtl/subtractor_pipe_pkg.sv | 34 +++
 rtl/subtractor_pipe_sub_slice.sv | 26 ++
 rtl/subtractor_pipe.sv | 153 +++++++++++++++
 tb/tb_subtractor_pipe.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/subtractor_pipe_pkg.sv
// Shared types and helpers for the pipelined subtractor / comparator.
package subtractor_pipe_pkg;

    typedef enum logic {
        CMP_UNSIGNED = 1'b0,
        CMP_SIGNED   = 1'b1
    } cmp_mode_e;

    typedef struct packed {
        logic lt;
        logic eq;
        logic gt;
    } cmp_flags_t;

    function automatic int calc_nstg(input int width, input int stage_w);
        return width / stage_w;
    endfunction

    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic diff_msb);
        return (a_msb ^ b_msb) & (a_msb ^ diff_msb);
    endfunction

    // In signed mode the true sign of A-B is the result sign corrected by overflow.
    function automatic cmp_flags_t resolve_flags(input cmp_mode_e mode, input logic borrow,
                                                 input logic zero, input logic diff_msb,
                                                 input logic ovf);
        cmp_flags_t f;
        f.lt = (mode == CMP_SIGNED) ? (diff_msb ^ ovf) : borrow;
        f.eq = zero;
        f.gt = ~f.lt & ~zero;
        return f;
    endfunction

endpackage

// File: rtl/subtractor_pipe_sub_slice.sv
// STAGE_W-bit combinational ripple-borrow subtractor slice.
module sub_slice #(
    parameter int W = 8
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_bin,
    output logic [W-1:0] o_diff,
    output logic         o_bout,
    output logic         o_zero
);

    // Ripple the borrow from LSB to MSB.
    always_comb begin : ripple
        logic v_bw;
        v_bw   = i_bin;
        o_diff = {W{1'b0}};
        for (int i = 0; i < W; i++) begin
            o_diff[i] = i_a[i] ^ i_b[i] ^ v_bw;
            v_bw      = (~i_a[i] & i_b[i]) | (~(i_a[i] ^ i_b[i]) & v_bw);
        end
        o_bout = v_bw;
        o_zero = (o_diff == {W{1'b0}});
    end

endmodule

// File: rtl/subtractor_pipe.sv
// Pipelined A-B subtractor and comparator, one STAGE_W slice per stage.
// Optional macro SUBTRACTOR_PIPE_OVF_EN adds the o_ovf signed-overflow output.
module subtractor_pipe
    import subtractor_pipe_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int STAGE_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_signed,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_borrow,
    output logic             o_lt,
    output logic             o_eq,
`ifdef SUBTRACTOR_PIPE_OVF_EN
    output logic             o_gt,
    output logic             o_ovf
`else
    output logic             o_gt
`endif
);

    localparam int NSTG = calc_nstg(WIDTH, STAGE_W);

    logic [WIDTH-1:0]   r_a    [NSTG];
    logic [WIDTH-1:0]   r_b    [NSTG];
    logic [WIDTH-1:0]   r_diff [NSTG];
    logic               r_vld  [NSTG];
    logic               r_bo   [NSTG];
    logic               r_zero [NSTG];
    logic               r_sgn  [NSTG];
    cmp_flags_t         r_flags;
`ifdef SUBTRACTOR_PIPE_OVF_EN
    logic               r_ovf;
`endif

    logic [WIDTH-1:0]   w_a     [NSTG];
    logic [WIDTH-1:0]   w_b     [NSTG];
    logic [WIDTH-1:0]   w_dprev [NSTG];
    logic [WIDTH-1:0]   w_dnext [NSTG];
    logic [STAGE_W-1:0] w_sdiff [NSTG];
    logic [NSTG-1:0]    w_vin;
    logic [NSTG-1:0]    w_sgn;
    logic [NSTG-1:0]    w_bin;
    logic [NSTG-1:0]    w_zin;
    logic [NSTG-1:0]    w_bout;
    logic [NSTG-1:0]    w_szero;
    logic               w_adv;
    logic               w_ovf;
    cmp_flags_t         w_flags;

    assign w_adv = ~r_vld[NSTG-1] | i_ready;

    for (genvar k = 0; k < NSTG; k++) begin : gen_stg
        logic [WIDTH-1:0] w_merge;

        // Stage 0 takes the raw operands; later stages take the skewed copies.
        if (k == 0) begin : gen_head
            assign w_a[k]     = i_a;
            assign w_b[k]     = i_b;
            assign w_dprev[k] = {WIDTH{1'b0}};
            assign w_vin[k]   = i_valid;
            assign w_sgn[k]   = i_signed;
            assign w_bin[k]   = 1'b0;
            assign w_zin[k]   = 1'b1;
        end else begin : gen_body
            assign w_a[k]     = r_a[k-1];
            assign w_b[k]     = r_b[k-1];
            assign w_dprev[k] = r_diff[k-1];
            assign w_vin[k]   = r_vld[k-1];
            assign w_sgn[k]   = r_sgn[k-1];
            assign w_bin[k]   = r_bo[k-1];
            assign w_zin[k]   = r_zero[k-1];
        end

        sub_slice #(
            .W (STAGE_W)
        ) u_slice (
            .i_a    (w_a[k][k*STAGE_W +: STAGE_W]),
            .i_b    (w_b[k][k*STAGE_W +: STAGE_W]),
            .i_bin  (w_bin[k]),
            .o_diff (w_sdiff[k]),
            .o_bout (w_bout[k]),
            .o_zero (w_szero[k])
        );

        // Drop this stage's slice into the diff word carried from earlier stages.
        always_comb begin
            w_merge                         = w_dprev[k];
            w_merge[k*STAGE_W +: STAGE_W]   = w_sdiff[k];
        end

        assign w_dnext[k] = w_merge;
    end

    assign w_ovf   = signed_ovf(w_a[NSTG-1][WIDTH-1], w_b[NSTG-1][WIDTH-1],
                                w_sdiff[NSTG-1][STAGE_W-1]);
    assign w_flags = resolve_flags(cmp_mode_e'(w_sgn[NSTG-1]), w_bout[NSTG-1],
                                   w_zin[NSTG-1] & w_szero[NSTG-1],
                                   w_sdiff[NSTG-1][STAGE_W-1], w_ovf);

    // Pipeline registers: every stage shifts together on advance, otherwise holds.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < NSTG; k++) begin
                r_a[k]    <= {WIDTH{1'b0}};
                r_b[k]    <= {WIDTH{1'b0}};
                r_diff[k] <= {WIDTH{1'b0}};
                r_vld[k]  <= 1'b0;
                r_bo[k]   <= 1'b0;
                r_zero[k] <= 1'b0;
                r_sgn[k]  <= 1'b0;
            end
            r_flags <= cmp_flags_t'(3'b000);
`ifdef SUBTRACTOR_PIPE_OVF_EN
            r_ovf   <= 1'b0;
`endif
        end else if (w_adv) begin
            for (int k = 0; k < NSTG; k++) begin
                r_a[k]    <= w_a[k];
                r_b[k]    <= w_b[k];
                r_diff[k] <= w_dnext[k];
                r_vld[k]  <= w_vin[k];
                r_bo[k]   <= w_bout[k];
                r_zero[k] <= w_zin[k] & w_szero[k];
                r_sgn[k]  <= w_sgn[k];
            end
            r_flags <= w_flags;
`ifdef SUBTRACTOR_PIPE_OVF_EN
            r_ovf   <= w_ovf;
`endif
        end
    end

    assign o_ready  = w_adv;
    assign o_valid  = r_vld[NSTG-1];
    assign o_diff   = r_diff[NSTG-1];
    assign o_borrow = r_bo[NSTG-1];
    assign o_lt     = r_flags.lt;
    assign o_eq     = r_flags.eq;
    assign o_gt     = r_flags.gt;
`ifdef SUBTRACTOR_PIPE_OVF_EN
    assign o_ovf    = r_ovf;
`endif

endmodule

// File: tb/tb_subtractor_pipe.sv
// Scoreboard bench for subtractor_pipe: random stream plus directed corner cases.
module tb_subtractor_pipe;

    localparam int WIDTH   = 32;
    localparam int STAGE_W = 8;
    localparam int NSTG    = WIDTH / STAGE_W;

    logic             i_clk = 1'b0;
    logic             i_rst_n = 1'b0;
    logic             i_valid = 1'b0;
    logic             o_ready;
    logic [WIDTH-1:0] i_a = 32'h0;
    logic [WIDTH-1:0] i_b = 32'h0;
    logic             i_signed = 1'b0;
    logic             o_valid;
    logic             i_ready = 1'b1;
    logic [WIDTH-1:0] o_diff;
    logic             o_borrow;
    logic             o_lt;
    logic             o_eq;
    logic             o_gt;
`ifdef SUBTRACTOR_PIPE_OVF_EN
    logic             o_ovf;
`endif

    typedef struct {
        logic [WIDTH-1:0] diff;
        logic             borrow;
        logic             lt;
        logic             eq;
        logic             gt;
        logic             ovf;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_in     = 0;
    int   n_out    = 0;

    logic             stall_pend = 1'b0;
    logic [WIDTH-1:0] held_diff;
    logic [3:0]       held_flags;

    subtractor_pipe #(
        .WIDTH   (WIDTH),
        .STAGE_W (STAGE_W)
    ) dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_a      (i_a),
        .i_b      (i_b),
        .i_signed (i_signed),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_diff   (o_diff),
        .o_borrow (o_borrow),
        .o_lt     (o_lt),
        .o_eq     (o_eq),
`ifdef SUBTRACTOR_PIPE_OVF_EN
        .o_gt     (o_gt),
        .o_ovf    (o_ovf)
`else
        .o_gt     (o_gt)
`endif
    );

    always #5 i_clk = ~i_clk;

    // Reference: plain integer arithmetic on the operands.
    function automatic exp_t ref_model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                       input logic s);
        exp_t e;
        longint sa, sb, sd;
        sa       = longint'($signed(a));
        sb       = longint'($signed(b));
        sd       = sa - sb;
        e.diff   = a - b;
        e.borrow = (a < b);
        e.ovf    = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
        e.eq     = (a == b);
        e.lt     = s ? (sa < sb) : (a < b);
        e.gt     = !e.lt && !e.eq;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Capture: every accepted operand pair pushes its expected result.
    always @(negedge i_clk) begin
        if (i_rst_n && i_valid && o_ready) begin
            sb_q.push_back(ref_model(i_a, i_b, i_signed));
            n_in++;
        end
    end

    // Monitor: pop and compare on each output transfer, watch stalls and handshake.
    always @(negedge i_clk) begin
        if (!i_rst_n) begin
            sb_q.delete();
            stall_pend = 1'b0;
            chk("reset_valid", {63'd0, o_valid}, 64'd0);
        end else begin
            exp_t e;
            chk("ready_rule", {63'd0, o_ready}, {63'd0, (!o_valid || i_ready)});
            if (stall_pend) begin
                chk("stall_valid", {63'd0, o_valid}, 64'd1);
                chk("stall_diff", {32'd0, o_diff}, {32'd0, held_diff});
                chk("stall_flags", {60'd0, o_borrow, o_lt, o_eq, o_gt}, {60'd0, held_flags});
            end
            if (o_valid)
                chk("onehot", 64'($countones({o_lt, o_eq, o_gt})), 64'd1);
            if (o_valid && i_ready) begin
                n_out++;
                if (sb_q.size() == 0) begin
                    chk("unexpected_out", 64'd1, 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("diff", {32'd0, o_diff}, {32'd0, e.diff});
                    chk("borrow", {63'd0, o_borrow}, {63'd0, e.borrow});
                    chk("flags", {61'd0, o_lt, o_eq, o_gt}, {61'd0, e.lt, e.eq, e.gt});
`ifdef SUBTRACTOR_PIPE_OVF_EN
                    chk("ovf", {63'd0, o_ovf}, {63'd0, e.ovf});
`endif
                end
            end
            stall_pend = o_valid && !i_ready;
            held_diff  = o_diff;
            held_flags = {o_borrow, o_lt, o_eq, o_gt};
        end
    end

    // Single transaction into an empty pipe; checks latency and fixed expected values.
    task automatic send_one(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic s, input logic [WIDTH-1:0] x_diff, input logic x_borrow,
                            input logic [2:0] x_ltegt);
        int cyc;
        @(posedge i_clk); #1;
        i_a = a; i_b = b; i_signed = s; i_valid = 1'b1; i_ready = 1'b1;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        cyc = 1;
        while (!o_valid && cyc < 4 * NSTG + 4) begin
            @(posedge i_clk); #1;
            cyc++;
        end
        chk({name, "_latency"}, 64'(cyc), 64'(NSTG));
        chk({name, "_diff"}, {32'd0, o_diff}, {32'd0, x_diff});
        chk({name, "_borrow"}, {63'd0, o_borrow}, {63'd0, x_borrow});
        chk({name, "_ltegt"}, {61'd0, o_lt, o_eq, o_gt}, {61'd0, x_ltegt});
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent, guard, stale;
        logic have, acc;
        logic [WIDTH-1:0] ra, rb;
        logic rs;

        // Reset state
        repeat (2) @(posedge i_clk);
        #2;
        chk("rst_o_valid", {63'd0, o_valid}, 64'd0);
        chk("rst_o_diff", {32'd0, o_diff}, 64'd0);
        chk("rst_flags", {60'd0, o_borrow, o_lt, o_eq, o_gt}, 64'd0);
        chk("rst_o_ready", {63'd0, o_ready}, 64'd1);
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;

        // Directed corner cases
        send_one("u5m3",   32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b0, 3'b001);
        send_one("u0m1",   32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 3'b100);
        send_one("s0m1",   32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b1, 3'b100);
        send_one("s_ovf",  32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b0, 3'b100);
        send_one("u_min",  32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 3'b001);
        send_one("ripple", 32'h0100_0000, 32'h0000_0001, 1'b0, 32'h00FF_FFFF, 1'b0, 3'b001);
        send_one("equal",  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 32'h0000_0000, 1'b0, 3'b010);
        send_one("s_gt",   32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 32'h0000_0002, 1'b1, 3'b001);

        // Random stream with random backpressure
        @(posedge i_clk); #1;
        sent = 0; guard = 0; have = 1'b0;
        ra = 32'h0; rb = 32'h0; rs = 1'b0;
        while (sent < 24 && guard < 2000) begin
            if (!have) begin
                ra = $urandom;
                case ($urandom_range(0, 4))
                    0: rb = ra;
                    1: rb = ra ^ 32'($urandom_range(0, 255));
                    2: rb = 32'h8000_0000;
                    default: rb = $urandom;
                endcase
                rs   = 1'($urandom_range(0, 1));
                have = 1'b1;
            end
            i_a = ra; i_b = rb; i_signed = rs;
            i_valid = ($urandom_range(0, 3) != 0);
            i_ready = ($urandom_range(0, 2) != 0);
            @(negedge i_clk);
            acc = i_valid && o_ready;
            @(posedge i_clk); #1;
            if (acc) begin
                have = 1'b0;
                sent++;
            end
            guard++;
        end
        chk("stream_sent", 64'(sent), 64'd24);
        i_valid = 1'b0;
        i_ready = 1'b1;
        guard = 0;
        while (sb_q.size() != 0 && guard < 50) begin
            @(posedge i_clk); #1;
            guard++;
        end
        @(posedge i_clk); #1;
        chk("drain_empty", 64'(sb_q.size()), 64'd0);
        chk("in_out_count", 64'(n_out), 64'(n_in));

        // Reset with transactions in flight
        i_ready = 1'b1;
        for (int i = 0; i < NSTG; i++) begin
            i_a = $urandom; i_b = $urandom; i_signed = 1'b0; i_valid = 1'b1;
            @(posedge i_clk); #1;
        end
        i_valid = 1'b0;
        chk("pre_rst_valid", {63'd0, o_valid}, 64'd1);
        i_rst_n = 1'b0;
        #1;
        chk("rst_drops_valid", {63'd0, o_valid}, 64'd0);
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        stale = 0;
        for (int i = 0; i < 3 * NSTG; i++) begin
            @(posedge i_clk); #1;
            if (o_valid) stale++;
        end
        chk("no_stale", 64'(stale), 64'd0);
        send_one("post_rst", 32'h1234_5678, 32'h0000_5678, 1'b0, 32'h1234_0000, 1'b0, 3'b001);
        repeat (3) @(posedge i_clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
